// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader that streams an image into CPU RAM.
package prog_loader_pkg;

  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SETUP,
    STROBE,
    HOLD,
    WAIT_CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Loads DEPTH bytes from a valid/ready stream into CPU RAM with a setup/strobe/hold
// write cycle per word, then verifies a trailing two's-complement checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              fastClk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_mode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              wr_strobe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W     = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                xfer;
  logic                csum_ok;

  // Checksum accumulation wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign in_ready  = (state == WAIT_BYTE) || (state == WAIT_CSUM);
  assign prog_mode = (state == WAIT_BYTE) || (state == SETUP) || (state == STROBE) ||
                     (state == HOLD)      || (state == WAIT_CSUM);
  assign busy      = prog_mode;
  assign wr_strobe = (state == STROBE);
  assign done      = (state == DONE);
  assign err       = (state == ERROR);
  assign addr      = addr_q;
  assign data      = data_q;
  assign xfer      = in_valid & in_ready;
  assign csum_ok   = (csum_add(acc_q, in_data) == '0);

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        // start wins over any byte offered in the same cycle (in_ready is low here)
        if (start) state_nxt = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (xfer) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt_q == CNT_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        state_nxt = (addr_q == LAST_ADDR) ? WAIT_CSUM : WAIT_BYTE;
      end
      WAIT_CSUM: begin
        if (xfer) state_nxt = csum_ok ? DONE : ERROR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // data_q only carries a byte from SETUP through HOLD, so it reads zero elsewhere.
  always_ff @(posedge fastClk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addr_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
          end
        end
        WAIT_BYTE: begin
          if (xfer) begin
            data_q <= in_data;
            acc_q  <= csum_add(acc_q, in_data);
          end
        end
        SETUP: begin
          cnt_q <= '0;
        end
        STROBE: begin
          cnt_q <= cnt_q + 1'b1;
        end
        HOLD: begin
          data_q <= '0;
          if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: two instances (1- and 3-cycle strobes) share stimulus,
// one is observed at a time and compared against an image/checksum reference model.
module tb_prog_loader;

  localparam int DEPTH = 16;

  logic       fastClk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;
  logic       sel;

  logic       a_in_ready, a_prog_mode, a_wr_strobe, a_busy, a_done, a_err;
  logic [3:0] a_addr;
  logic [7:0] a_data;
  logic       b_in_ready, b_prog_mode, b_wr_strobe, b_busy, b_done, b_err;
  logic [3:0] b_addr;
  logic [7:0] b_data;

  logic       o_in_ready, o_prog_mode, o_wr_strobe, o_busy, o_done, o_err;
  logic [3:0] o_addr;
  logic [7:0] o_data;

  prog_loader #(.DEPTH(DEPTH), .STROBE_CYCLES(1)) dut_s1 (
    .fastClk(fastClk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .prog_mode(a_prog_mode), .addr(a_addr), .data(a_data),
    .wr_strobe(a_wr_strobe), .busy(a_busy), .done(a_done), .err(a_err)
  );

  prog_loader #(.DEPTH(DEPTH), .STROBE_CYCLES(3)) dut_s3 (
    .fastClk(fastClk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .prog_mode(b_prog_mode), .addr(b_addr), .data(b_data),
    .wr_strobe(b_wr_strobe), .busy(b_busy), .done(b_done), .err(b_err)
  );

  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_prog_mode = sel ? b_prog_mode : a_prog_mode;
  assign o_wr_strobe = sel ? b_wr_strobe : a_wr_strobe;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_done      = sel ? b_done      : a_done;
  assign o_err       = sel ? b_err       : a_err;
  assign o_addr      = sel ? b_addr      : a_addr;
  assign o_data      = sel ? b_data      : a_data;

  always #5 fastClk = ~fastClk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fastClk);
    #1;
  endtask

  // Strobe monitor: one record per completed write strobe.
  int   q_addr[$], q_data[$], q_len[$], q_start[$];
  bit   q_stab[$];
  int   cyc = 0;
  int   viol_zero = 0, viol_busy = 0;
  logic p_strobe = 1'b0, p_prog = 1'b0, p_ready = 1'b0;
  logic [3:0] p_addr = '0;
  logic [7:0] p_data = '0;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  int   c_len, c_start;
  bit   c_stab;

  initial begin
    forever begin
      @(negedge fastClk);
      cyc++;
      if ((o_in_ready || !o_prog_mode) && (o_data != 8'h00 || o_wr_strobe)) viol_zero++;
      if (o_busy !== o_prog_mode) viol_busy++;
      if (o_wr_strobe && !p_strobe) begin
        c_addr  = o_addr;
        c_data  = o_data;
        c_len   = 1;
        c_start = cyc;
        c_stab  = p_prog && !p_ready && (p_addr == o_addr) && (p_data == o_data);
      end else if (o_wr_strobe) begin
        c_len++;
        if (o_addr != c_addr || o_data != c_data) c_stab = 1'b0;
      end else if (p_strobe && !rst) begin
        q_addr.push_back(c_addr);
        q_data.push_back(c_data);
        q_len.push_back(c_len);
        q_start.push_back(c_start);
        q_stab.push_back(c_stab && o_prog_mode && !o_in_ready &&
                         (o_addr == c_addr) && (o_data == c_data));
      end
      p_strobe = o_wr_strobe;
      p_prog   = o_prog_mode;
      p_ready  = o_in_ready;
      p_addr   = o_addr;
      p_data   = o_data;
    end
  end

  logic [7:0] img [DEPTH];
  int         strobe_w;

  function automatic logic [7:0] good_csum();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += img[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_len.delete(); q_start.delete(); q_stab.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_prog_mode"}, o_prog_mode, 0);
    chk({tag, "_wr_strobe"}, o_wr_strobe, 0);
    chk({tag, "_busy"},      o_busy,      0);
    chk({tag, "_in_ready"},  o_in_ready,  0);
    chk({tag, "_done"},      o_done,      0);
    chk({tag, "_err"},       o_err,       0);
    chk({tag, "_addr"},      o_addr,      0);
    chk({tag, "_data"},      o_data,      0);
  endtask

  task automatic load(input logic [7:0] csum, input int gap, input int pulse_addr);
    int  idx = 0, t = 0, sum = 0;
    bit  v, hs, pulsed = 0, exp_ok;
    for (int i = 0; i < DEPTH; i++) sum += img[i];
    exp_ok = (((sum + csum) % 256) == 0);
    clear_q();
    start = 1; in_valid = 1; in_data = 8'hEE;
    step();
    start = 0;
    chk("start_busy", o_busy, 1);
    chk("start_clr_done", o_done, 0);
    chk("start_clr_err", o_err, 0);
    while (idx <= DEPTH && t < 2000) begin
      if (pulse_addr >= 0 && !pulsed && o_busy && o_addr == 4'(pulse_addr)) begin
        start = 1; pulsed = 1;
      end else begin
        start = 0;
      end
      v = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      in_valid = v;
      in_data  = !v ? 8'($urandom) : (idx < DEPTH) ? img[idx] : csum;
      hs = v && o_in_ready;
      step();
      t++;
      if (hs) idx++;
    end
    start = 0; in_valid = 0;
    chk("load_in_time", t < 2000, 1);
    chk("end_done", o_done, exp_ok);
    chk("end_err", o_err, !exp_ok);
    chk("end_prog_mode", o_prog_mode, 0);
    chk("end_busy", o_busy, 0);
    chk("end_in_ready", o_in_ready, 0);
    chk("end_data", o_data, 0);
    repeat (3) step();
    chk("hold_done", o_done, exp_ok);
    chk("hold_err", o_err, !exp_ok);
    chk("n_strobes", q_addr.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < q_addr.size(); i++) begin
      chk($sformatf("addr[%0d]", i), q_addr[i], i);
      chk($sformatf("data[%0d]", i), q_data[i], img[i]);
      chk($sformatf("len[%0d]", i), q_len[i], strobe_w);
      chk($sformatf("stable[%0d]", i), q_stab[i], 1);
      if (gap == 0 && i > 0)
        chk($sformatf("spacing[%0d]", i), q_start[i] - q_start[i-1], 3 + strobe_w);
    end
  endtask

  task automatic reset_mid();
    int idx = 0, t = 0;
    bit hs, hit = 0;
    clear_q();
    start = 1; in_valid = 1; in_data = 8'hEE;
    step();
    start = 0;
    while (!hit && t < 400) begin
      if (o_wr_strobe && o_addr == 4'd5) begin
        hit = 1;
      end else begin
        in_valid = 1; in_data = img[idx];
        hs = o_in_ready;
        step();
        t++;
        if (hs) idx++;
      end
    end
    chk("rst_reached_addr5", hit, 1);
    rst = 1; in_valid = 1; in_data = img[idx];
    step();
    chk_idle_outputs("midrst");
    step();
    rst = 0; in_valid = 0;
    chk("midrst_strobes_kept", q_addr.size(), 5);
    step();
  endtask

  task automatic rand_img();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(255));
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = '0; sel = 0; strobe_w = 1;
    repeat (3) step();
    chk_idle_outputs("reset_s1");
    rst = 0;
    step();

    for (int i = 0; i < DEPTH; i++) img[i] = 8'(i + 1);
    load(8'h78, 0, -1);
    load(8'h77, 0, -1);

    repeat (3) begin
      rand_img();
      load(($urandom_range(1) == 1) ? good_csum() : 8'(good_csum() + $urandom_range(1, 255)),
           40, -1);
    end

    rand_img();
    load(good_csum(), 0, 7);

    rand_img();
    reset_mid();
    load(good_csum(), 0, -1);

    sel = 1; strobe_w = 3;
    rst = 1;
    repeat (2) step();
    chk_idle_outputs("reset_s3");
    rst = 0;
    step();
    repeat (3) begin
      rand_img();
      load(($urandom_range(1) == 1) ? good_csum() : 8'(good_csum() + $urandom_range(1, 255)),
           50, -1);
    end
    for (int i = 0; i < DEPTH; i++) img[i] = 8'(i + 1);
    load(8'h78, 0, -1);

    chk("data_zero_outside_write", viol_zero, 0);
    chk("busy_matches_prog_mode", viol_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
